// File: rtl/sobel_magnitude.sv
// Sobel gradient magnitude (L1, or alpha-max-beta-min when SOBEL_MAG_L2_EN is defined), border masking, edge flag, frame-last flag.
// Latency 2 cycles; valid/ready with full backpressure, ready_o = ~valid_o | ready_i.
module sobel_magnitude #(
   parameter int WIDTH_P  = 8,
   parameter int DEPTH_P  = 16,
   parameter int HEIGHT_P = 16,
   parameter int THRESH_P = 64
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic signed [2*WIDTH_P-1:0] gx_i,
   input  logic signed [2*WIDTH_P-1:0] gy_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [WIDTH_P-1:0]        mag_o,
   output logic                      edge_o,
   output logic                      last_o
);
   localparam int GW = 2*WIDTH_P;
   localparam int CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
   localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(DEPTH_P-1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_P-1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [WIDTH_P-1:0] THRESH_C = WIDTH_P'(THRESH_P);

   logic              en, accept;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              v1, v2;
   logic [GW-1:0]     abs_x, abs_y, a1, b1;
   logic              border1, last1;
   logic [GW:0]       sum;
   logic [WIDTH_P-1:0] mag_sat;

   assign en      = ~v2 | ready_i;
   assign ready_o = en;
   assign accept  = valid_i & en;
   assign valid_o = v2;

   // Unsigned GW-bit result, so the most negative input maps to 2^(GW-1) without overflow
   assign abs_x = gx_i[GW-1] ? (~$unsigned(gx_i) + 1'b1) : $unsigned(gx_i);
   assign abs_y = gy_i[GW-1] ? (~$unsigned(gy_i) + 1'b1) : $unsigned(gy_i);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         v1      <= 1'b0;
         a1      <= '0;
         b1      <= '0;
         border1 <= 1'b0;
         last1   <= 1'b0;
      end else if (en) begin
         v1 <= valid_i;
         if (valid_i) begin
            a1      <= abs_x;
            b1      <= abs_y;
            border1 <= (row < ROW_TWO) | (col < COL_TWO);
            last1   <= (row == ROW_LAST) & (col == COL_LAST);
         end
      end
   end

   always_comb begin
      sum = '0;
`ifdef SOBEL_MAG_L2_EN
      if (a1 >= b1) sum = {1'b0, a1} + {2'b00, b1[GW-1:1]};
      else          sum = {1'b0, b1} + {2'b00, a1[GW-1:1]};
`else
      sum = {1'b0, a1} + {1'b0, b1};
`endif
      mag_sat = (|sum[GW:WIDTH_P]) ? '1 : sum[WIDTH_P-1:0];
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         v2     <= 1'b0;
         mag_o  <= '0;
         edge_o <= 1'b0;
         last_o <= 1'b0;
      end else if (en) begin
         v2     <= v1;
         mag_o  <= border1 ? '0 : mag_sat;
         edge_o <= ~border1 & (mag_sat >= THRESH_C);
         last_o <= last1;
      end
   end
endmodule
